input_buffer: RTL and testbench

- Per-virtual-channel flit store plus wormhole VC state machine.
- Instantiated once per VC inside each router input port. It sits upstream of the crossbar and the VC/switch allocators.
- Buffers incoming flits and holds the route computed for the packet at its front. It requests a downstream VC for each head flit, then requests the switch once per flit until the tail leaves.
- Output flits carry the allocated downstream VC id.

---
 rtl/noc_params.sv | 29 ++
 rtl/circular_buffer.sv | 60 ++++++
 rtl/input_buffer.sv | 97 +++++++++
 tb/tb_input_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC types: flit layout, flit labels, router ports and the
// input-buffer VC state encoding.
package noc_params;

    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = $clog2(VC_NUM);
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [DATA_W-1:0]    data;
    } flit_t;

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} ib_state_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/circular_buffer.sv
// Flit FIFO with wrapping pointers and an occupancy count; raises a sticky
// error on a push into a full buffer without a pop, or on a pop while empty.
module circular_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  push,
    input  logic  pop,
    output flit_t data_o,
    output logic  is_empty,
    output logic  is_full,
    output logic  error
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);

    flit_t            mem [BUFFER_SIZE];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign is_empty = (count == '0);
    assign is_full  = (count == (PTR_W+1)'(BUFFER_SIZE));
    assign do_pop   = pop && !is_empty;
    // A pop on the same edge frees the slot, so a full buffer may still accept.
    assign do_push  = push && (!is_full || do_pop);
    assign data_o   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if ((push && is_full && !pop) || (pop && is_empty))
                error <= 1'b1;
        end
    end

endmodule

// File: rtl/input_buffer.sv
// Per-VC input buffer: flit storage plus the wormhole IDLE/VA/ACTIVE state
// machine that requests a downstream VC per packet and the switch per flit.
module input_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              data_i,
    input  logic               valid_i,
    input  port_t              out_port_i,
    input  logic               vc_valid_i,
    input  logic [VC_SIZE-1:0] vc_new_i,
    input  logic               sa_grant_i,
    output flit_t              flit_o,
    output port_t              out_port_o,
    output logic               vc_request_o,
    output logic               switch_request_o,
    output logic               is_empty_o,
    output logic               is_full_o,
    output logic               error_o
);

    ib_state_t          state;
    flit_t              front;
    logic [VC_SIZE-1:0] downstream_vc;
    logic               buf_error;
    logic               fsm_error;
    logic               idle_drop;
    logic               active_pop;

    // A BODY/TAIL at the front while idle has no packet context and is discarded.
    assign idle_drop  = (state == IDLE) && !is_empty_o && !is_head(front.flit_label);
    assign active_pop = (state == ACTIVE) && sa_grant_i && !is_empty_o;

    circular_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .push     (valid_i),
        .pop      (idle_drop || active_pop),
        .data_o   (front),
        .is_empty (is_empty_o),
        .is_full  (is_full_o),
        .error    (buf_error)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            out_port_o    <= LOCAL;
            downstream_vc <= '0;
            vc_request_o  <= 1'b0;
            fsm_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!is_empty_o) begin
                        if (is_head(front.flit_label)) begin
                            out_port_o   <= out_port_i;
                            vc_request_o <= 1'b1;
                            state        <= VA;
                        end else begin
                            fsm_error <= 1'b1;
                        end
                    end
                end
                VA: begin
                    if (vc_valid_i) begin
                        downstream_vc <= vc_new_i;
                        vc_request_o  <= 1'b0;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (active_pop && is_tail(front.flit_label))
                        state <= IDLE;
                end
                default: begin
                    vc_request_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign switch_request_o = (state == ACTIVE) && !is_empty_o;
    assign error_o          = buf_error || fsm_error;

    always_comb begin
        flit_o = front;
        if (state == ACTIVE)
            flit_o.vc_id = downstream_vc;
    end

endmodule

// File: tb/tb_input_buffer.sv
// Scenario bench for input_buffer: expected output flits are queued when
// driven and popped when the switch grant consumes them.
module tb_input_buffer;
    import noc_params::*;

    logic               clk = 1'b0;
    logic               rst;
    flit_t              data_i;
    logic               valid_i;
    port_t              out_port_i;
    logic               vc_valid_i;
    logic [VC_SIZE-1:0] vc_new_i;
    logic               sa_grant_i;
    flit_t              flit_o;
    port_t              out_port_o;
    logic               vc_request_o;
    logic               switch_request_o;
    logic               is_empty_o;
    logic               is_full_o;
    logic               error_o;

    int    n_cmp = 0;
    int    n_bad = 0;
    flit_t exp_q[$];
    flit_t exp_f;

    always #5 clk = ~clk;

    input_buffer #(.BUFFER_SIZE(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .out_port_i       (out_port_i),
        .vc_valid_i       (vc_valid_i),
        .vc_new_i         (vc_new_i),
        .sa_grant_i       (sa_grant_i),
        .flit_o           (flit_o),
        .out_port_o       (out_port_o),
        .vc_request_o     (vc_request_o),
        .switch_request_o (switch_request_o),
        .is_empty_o       (is_empty_o),
        .is_full_o        (is_full_o),
        .error_o          (error_o)
    );

    function automatic flit_t mk(input flit_label_t l, input logic [VC_SIZE-1:0] v,
                                 input logic [DATA_W-1:0] d);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = v;
        f.data       = d;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; valid_i = 1'b0; vc_valid_i = 1'b0; sa_grant_i = 1'b0;
        vc_new_i = '0; out_port_i = LOCAL; data_i = '0;
        exp_q.delete();
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        n_cmp++; if (is_empty_o !== 1'b1 || is_full_o !== 1'b0) begin n_bad++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", is_empty_o, is_full_o); end
        n_cmp++; if (vc_request_o !== 1'b0 || switch_request_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: vc=%b sw=%b want 0/0", vc_request_o, switch_request_o); end
        n_cmp++; if (error_o !== 1'b0 || out_port_o !== LOCAL) begin n_bad++; $display("FAIL reset_misc: err=%b port=%0d want 0/LOCAL", error_o, out_port_o); end
        rst = 1'b0;
    endtask

    task automatic test_single_packet;
        do_reset();
        data_i = mk(HEAD, 2'd0, 16'h00E4); valid_i = 1'b1; out_port_i = EAST;
        exp_q.push_back(mk(HEAD, 2'd2, 16'h00E4));
        tick();
        valid_i = 1'b0;
        n_cmp++; if (vc_request_o !== 1'b0 || is_empty_o !== 1'b0) begin n_bad++; $display("FAIL single_idle: vc=%b empty=%b want 0/0", vc_request_o, is_empty_o); end
        tick();
        n_cmp++; if (vc_request_o !== 1'b1) begin n_bad++; $display("FAIL single_va: vc_request=%b want 1", vc_request_o); end
        n_cmp++; if (out_port_o !== EAST) begin n_bad++; $display("FAIL single_port: got %0d want EAST", out_port_o); end
        data_i = mk(TAIL, 2'd0, 16'h00E5); valid_i = 1'b1; out_port_i = LOCAL;
        exp_q.push_back(mk(TAIL, 2'd2, 16'h00E5));
        tick();
        valid_i = 1'b0;
        n_cmp++; if (vc_request_o !== 1'b1 || switch_request_o !== 1'b0) begin n_bad++; $display("FAIL single_va_hold: vc=%b sw=%b want 1/0", vc_request_o, switch_request_o); end
        vc_valid_i = 1'b1; vc_new_i = 2'd2;
        tick();
        vc_valid_i = 1'b0;
        n_cmp++; if (vc_request_o !== 1'b0 || switch_request_o !== 1'b1) begin n_bad++; $display("FAIL single_active: vc=%b sw=%b want 0/1", vc_request_o, switch_request_o); end
        for (int i = 0; i < 2; i++) begin
            exp_f = exp_q.pop_front();
            n_cmp++; if (flit_o !== exp_f) begin n_bad++; $display("FAIL single_flit%0d: got %h want %h", i, flit_o, exp_f); end
            sa_grant_i = 1'b1;
            tick();
        end
        sa_grant_i = 1'b0;
        n_cmp++; if (switch_request_o !== 1'b0 || is_empty_o !== 1'b1 || error_o !== 1'b0) begin n_bad++; $display("FAIL single_done: sw=%b empty=%b err=%b want 0/1/0", switch_request_o, is_empty_o, error_o); end
        n_cmp++; if (out_port_o !== EAST) begin n_bad++; $display("FAIL single_port_hold: got %0d want EAST", out_port_o); end
        tick();
        n_cmp++; if (vc_request_o !== 1'b0) begin n_bad++; $display("FAIL single_idle_end: vc_request=%b want 0", vc_request_o); end
    endtask

    task automatic test_full;
        flit_label_t lbl;
        do_reset();
        out_port_i = SOUTH;
        for (int i = 0; i < 8; i++) begin
            lbl = (i == 0) ? HEAD : ((i == 7) ? TAIL : BODY);
            data_i = mk(lbl, 2'd0, 16'h0100 + 16'(i)); valid_i = 1'b1;
            exp_q.push_back(mk(lbl, 2'd1, 16'h0100 + 16'(i)));
            tick();
        end
        valid_i = 1'b0;
        n_cmp++; if (is_full_o !== 1'b1 || error_o !== 1'b0) begin n_bad++; $display("FAIL full_flag: full=%b err=%b want 1/0", is_full_o, error_o); end
        sa_grant_i = 1'b1;
        tick();
        sa_grant_i = 1'b0;
        n_cmp++; if (is_full_o !== 1'b1 || vc_request_o !== 1'b1) begin n_bad++; $display("FAIL full_grant_in_va: full=%b vc=%b want 1/1", is_full_o, vc_request_o); end
        data_i = mk(BODY, 2'd0, 16'hDEAD); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n_cmp++; if (error_o !== 1'b1 || is_full_o !== 1'b1) begin n_bad++; $display("FAIL full_overflow: err=%b full=%b want 1/1", error_o, is_full_o); end
        vc_valid_i = 1'b1; vc_new_i = 2'd1;
        tick();
        vc_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_f = exp_q.pop_front();
            n_cmp++; if (flit_o !== exp_f || switch_request_o !== 1'b1) begin n_bad++; $display("FAIL full_drain%0d: got %h sw=%b want %h sw=1", i, flit_o, switch_request_o, exp_f); end
            sa_grant_i = 1'b1;
            tick();
        end
        sa_grant_i = 1'b0;
        n_cmp++; if (is_empty_o !== 1'b1 || switch_request_o !== 1'b0) begin n_bad++; $display("FAIL full_empty: empty=%b sw=%b want 1/0", is_empty_o, switch_request_o); end
    endtask

    task automatic test_simultaneous;
        flit_label_t lbl;
        do_reset();
        out_port_i = WEST;
        for (int i = 0; i < 8; i++) begin
            lbl = (i == 0) ? HEAD : BODY;
            data_i = mk(lbl, 2'd0, 16'h0200 + 16'(i)); valid_i = 1'b1;
            exp_q.push_back(mk(lbl, 2'd3, 16'h0200 + 16'(i)));
            tick();
        end
        valid_i = 1'b0;
        vc_valid_i = 1'b1; vc_new_i = 2'd3;
        tick();
        vc_valid_i = 1'b0;
        n_cmp++; if (is_full_o !== 1'b1 || switch_request_o !== 1'b1) begin n_bad++; $display("FAIL simul_start: full=%b sw=%b want 1/1", is_full_o, switch_request_o); end
        for (int i = 0; i < 4; i++) begin
            lbl = (i == 3) ? TAIL : BODY;
            exp_f = exp_q.pop_front();
            n_cmp++; if (flit_o !== exp_f) begin n_bad++; $display("FAIL simul_flit%0d: got %h want %h", i, flit_o, exp_f); end
            data_i = mk(lbl, 2'd0, 16'h0210 + 16'(i)); valid_i = 1'b1; sa_grant_i = 1'b1;
            exp_q.push_back(mk(lbl, 2'd3, 16'h0210 + 16'(i)));
            tick();
            n_cmp++; if (is_full_o !== 1'b1 || error_o !== 1'b0) begin n_bad++; $display("FAIL simul_count%0d: full=%b err=%b want 1/0", i, is_full_o, error_o); end
        end
        valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_f = exp_q.pop_front();
            n_cmp++; if (flit_o !== exp_f) begin n_bad++; $display("FAIL simul_drain%0d: got %h want %h", i, flit_o, exp_f); end
            sa_grant_i = 1'b1;
            tick();
        end
        sa_grant_i = 1'b0;
        n_cmp++; if (is_empty_o !== 1'b1 || error_o !== 1'b0 || switch_request_o !== 1'b0) begin n_bad++; $display("FAIL simul_end: empty=%b err=%b sw=%b want 1/0/0", is_empty_o, error_o, switch_request_o); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        data_i = mk(HEADTAIL, 2'd3, 16'hA0A0); valid_i = 1'b1; out_port_i = NORTH;
        exp_q.push_back(mk(HEADTAIL, 2'd1, 16'hA0A0));
        tick();
        data_i = mk(HEADTAIL, 2'd3, 16'hB0B0);
        exp_q.push_back(mk(HEADTAIL, 2'd0, 16'hB0B0));
        tick();
        valid_i = 1'b0;
        n_cmp++; if (vc_request_o !== 1'b1 || out_port_o !== NORTH) begin n_bad++; $display("FAIL b2b_va1: vc=%b port=%0d want 1/NORTH", vc_request_o, out_port_o); end
        n_cmp++; if (flit_o.vc_id !== 2'd3) begin n_bad++; $display("FAIL b2b_stored_vc: got %0d want 3", flit_o.vc_id); end
        vc_valid_i = 1'b1; vc_new_i = 2'd1;
        tick();
        vc_valid_i = 1'b0;
        exp_f = exp_q.pop_front();
        n_cmp++; if (flit_o !== exp_f || switch_request_o !== 1'b1) begin n_bad++; $display("FAIL b2b_flit1: got %h sw=%b want %h sw=1", flit_o, switch_request_o, exp_f); end
        sa_grant_i = 1'b1; out_port_i = WEST;
        tick();
        sa_grant_i = 1'b0;
        n_cmp++; if (vc_request_o !== 1'b0 || switch_request_o !== 1'b0 || is_empty_o !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: vc=%b sw=%b empty=%b want 0/0/0", vc_request_o, switch_request_o, is_empty_o); end
        n_cmp++; if (out_port_o !== NORTH) begin n_bad++; $display("FAIL b2b_port_hold: got %0d want NORTH", out_port_o); end
        tick();
        n_cmp++; if (vc_request_o !== 1'b1 || out_port_o !== WEST) begin n_bad++; $display("FAIL b2b_va2: vc=%b port=%0d want 1/WEST", vc_request_o, out_port_o); end
        vc_valid_i = 1'b1; vc_new_i = 2'd0;
        tick();
        vc_valid_i = 1'b0;
        exp_f = exp_q.pop_front();
        n_cmp++; if (flit_o !== exp_f) begin n_bad++; $display("FAIL b2b_flit2: got %h want %h", flit_o, exp_f); end
        sa_grant_i = 1'b1;
        tick();
        sa_grant_i = 1'b0;
        n_cmp++; if (is_empty_o !== 1'b1 || error_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end: empty=%b err=%b want 1/0", is_empty_o, error_o); end
    endtask

    task automatic test_body_error;
        do_reset();
        data_i = mk(BODY, 2'd0, 16'h0B0D); valid_i = 1'b1; out_port_i = EAST;
        tick();
        valid_i = 1'b0;
        n_cmp++; if (error_o !== 1'b0 || is_empty_o !== 1'b0) begin n_bad++; $display("FAIL body_stored: err=%b empty=%b want 0/0", error_o, is_empty_o); end
        tick();
        n_cmp++; if (error_o !== 1'b1 || is_empty_o !== 1'b1 || vc_request_o !== 1'b0) begin n_bad++; $display("FAIL body_drop: err=%b empty=%b vc=%b want 1/1/0", error_o, is_empty_o, vc_request_o); end
        tick();
        n_cmp++; if (error_o !== 1'b1 || vc_request_o !== 1'b0) begin n_bad++; $display("FAIL body_sticky: err=%b vc=%b want 1/0", error_o, vc_request_o); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_port_i = SOUTH; valid_i = 1'b1;
        data_i = mk(BODY, 2'd0, 16'h0001); tick();
        data_i = mk(HEAD, 2'd0, 16'h0002); tick();
        data_i = mk(BODY, 2'd0, 16'h0003); tick();
        data_i = mk(BODY, 2'd0, 16'h0004); tick();
        valid_i = 1'b0;
        vc_valid_i = 1'b1; vc_new_i = 2'd2;
        tick();
        vc_valid_i = 1'b0;
        n_cmp++; if (switch_request_o !== 1'b1 || error_o !== 1'b1 || out_port_o !== SOUTH) begin n_bad++; $display("FAIL mid_pre: sw=%b err=%b port=%0d want 1/1/SOUTH", switch_request_o, error_o, out_port_o); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (switch_request_o !== 1'b0 || vc_request_o !== 1'b0 || is_empty_o !== 1'b1 || is_full_o !== 1'b0) begin n_bad++; $display("FAIL mid_async: sw=%b vc=%b empty=%b full=%b want 0/0/1/0", switch_request_o, vc_request_o, is_empty_o, is_full_o); end
        n_cmp++; if (error_o !== 1'b0 || out_port_o !== LOCAL) begin n_bad++; $display("FAIL mid_async_misc: err=%b port=%0d want 0/LOCAL", error_o, out_port_o); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (is_empty_o !== 1'b1 || vc_request_o !== 1'b0 || switch_request_o !== 1'b0) begin n_bad++; $display("FAIL mid_after: empty=%b vc=%b sw=%b want 1/0/0", is_empty_o, vc_request_o, switch_request_o); end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; vc_valid_i = 1'b0; sa_grant_i = 1'b0;
        vc_new_i = '0; out_port_i = LOCAL; data_i = '0;
        test_reset();
        test_single_packet();
        test_full();
        test_simultaneous();
        test_back_to_back();
        test_body_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
